// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: port ids, the request payload
// record and the grant-selection helper.
package mem_arb_pkg;

    typedef logic port_id_t;

    localparam port_id_t PORT_IMEM = 1'b0;
    localparam port_id_t PORT_DMEM = 1'b1;

    localparam int MEM_ARB_ADDR_W = 32;
    localparam int MEM_ARB_DATA_W = 32;

    typedef struct packed {
        logic [MEM_ARB_DATA_W/8-1:0] be;
        logic [MEM_ARB_ADDR_W-1:0]   addr;
        logic [MEM_ARB_DATA_W-1:0]   data;
    } mem_req_t;

    // A lone requester always wins; on contention the preferred port wins.
    function automatic port_id_t pick_port(input logic v0, input logic v1,
                                           input port_id_t preferred);
        if (v0 && v1) begin
            return preferred;
        end else if (v1) begin
            return PORT_DMEM;
        end
        return PORT_IMEM;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// DEPTH x 1-bit FIFO remembering which port issued each outstanding request.
// Pointers wrap naturally; a separate count disambiguates full from empty.
module tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  port_id_t                 push_tag,
    input  logic                     pop,
    output port_id_t                 head_tag,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] slots;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign head_tag = slots[rd_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_tag;
                wr_ptr        <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one in-order ext_mem port between the imem (port 0) and dmem (port 1)
// ports. Define MEM_ARB_FIXED_PRIO_EN to make dmem always win on contention.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                CLK,
    input  logic                RST_N,

    input  logic                p0_req_valid,
    output logic                p0_req_ready,
    input  logic [DATA_W/8-1:0] p0_req_be,
    input  logic [ADDR_W-1:0]   p0_req_addr,
    input  logic [DATA_W-1:0]   p0_req_data,
    output logic                p0_rsp_valid,
    output logic [DATA_W-1:0]   p0_rsp_data,

    input  logic                p1_req_valid,
    output logic                p1_req_ready,
    input  logic [DATA_W/8-1:0] p1_req_be,
    input  logic [ADDR_W-1:0]   p1_req_addr,
    input  logic [DATA_W-1:0]   p1_req_data,
    output logic                p1_rsp_valid,
    output logic [DATA_W-1:0]   p1_rsp_data,

    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic [DATA_W/8-1:0] m_req_be,
    output logic [ADDR_W-1:0]   m_req_addr,
    output logic [DATA_W-1:0]   m_req_data,
    input  logic                m_rsp_valid,
    input  logic [DATA_W-1:0]   m_rsp_data,

    output logic                err
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    port_id_t         grant;
    port_id_t         head_tag;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             rsp_pop;
    logic             can_issue;
    logic             any_req;
    logic             accept;

    assign fifo_empty = (fifo_count == '0);
    assign rsp_pop    = m_rsp_valid && !fifo_empty;
    assign can_issue  = !fifo_full || rsp_pop;
    assign any_req    = p0_req_valid || p1_req_valid;

    // Gating with RST_N keeps the downstream request quiet while reset is held.
    assign m_req_valid = RST_N && can_issue && any_req;
    assign accept      = m_req_valid && m_req_ready;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign grant = pick_port(p0_req_valid, p1_req_valid, PORT_DMEM);
`else
    port_id_t rr_prefer;

    assign grant = pick_port(p0_req_valid, p1_req_valid, rr_prefer);

    // Preference flips to the other port only when a transfer actually goes out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_prefer <= PORT_IMEM;
        end else if (accept) begin
            rr_prefer <= (grant == PORT_IMEM) ? PORT_DMEM : PORT_IMEM;
        end
    end
`endif

    assign p0_req_ready = accept && (grant == PORT_IMEM);
    assign p1_req_ready = accept && (grant == PORT_DMEM);

    always_comb begin
        m_req_be   = p0_req_be;
        m_req_addr = p0_req_addr;
        m_req_data = p0_req_data;
        if (grant == PORT_DMEM) begin
            m_req_be   = p1_req_be;
            m_req_addr = p1_req_addr;
            m_req_data = p1_req_data;
        end
    end

    assign p0_rsp_valid = rsp_pop && (head_tag == PORT_IMEM);
    assign p1_rsp_valid = rsp_pop && (head_tag == PORT_DMEM);
    assign p0_rsp_data  = m_rsp_data;
    assign p1_rsp_data  = m_rsp_data;

    // A response with nothing outstanding means the memory and arbiter disagree.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err <= 1'b0;
        end else if (m_rsp_valid && fifo_empty) begin
            err <= 1'b1;
        end
    end

    tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (CLK),
        .rst_n    (RST_N),
        .push     (accept),
        .push_tag (grant),
        .pop      (rsp_pop),
        .head_tag (head_tag),
        .full     (fifo_full),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based model. Honours MEM_ARB_FIXED_PRIO_EN.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic        CLK;
    logic        RST_N;
    logic        p0_req_valid, p0_req_ready, p0_rsp_valid;
    logic [3:0]  p0_req_be;
    logic [31:0] p0_req_addr, p0_req_data, p0_rsp_data;
    logic        p1_req_valid, p1_req_ready, p1_rsp_valid;
    logic [3:0]  p1_req_be;
    logic [31:0] p1_req_addr, p1_req_data, p1_rsp_data;
    logic        m_req_valid, m_req_ready, m_rsp_valid;
    logic [3:0]  m_req_be;
    logic [31:0] m_req_addr, m_req_data, m_rsp_data;
    logic        err;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_be(p0_req_be),
        .p0_req_addr(p0_req_addr), .p0_req_data(p0_req_data),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_be(p1_req_be),
        .p1_req_addr(p1_req_addr), .p1_req_data(p1_req_data),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_be(m_req_be),
        .m_req_addr(m_req_addr), .m_req_data(m_req_data),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
        .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        p0v;
        mem_req_t    p0;
        logic        p1v;
        mem_req_t    p1;
        logic        mrdy;
        logic        mrsp;
        logic [31:0] mrdata;
    } stim_t;

    typedef struct {
        stim_t       in;
        logic        mv, r0, r1, s0, s1;
        logic [31:0] addr;
        logic        err;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   tag_q[$];
    int   prefer_m;
    logic err_m;

    function automatic stim_t mkStim(logic p0v, logic [31:0] a0, logic [3:0] be0, logic [31:0] d0,
                                     logic p1v, logic [31:0] a1, logic [3:0] be1, logic [31:0] d1,
                                     logic mrdy, logic mrsp, logic [31:0] rd);
        stim_t s;
        s.p0v = p0v; s.p0.addr = a0; s.p0.be = be0; s.p0.data = d0;
        s.p1v = p1v; s.p1.addr = a1; s.p1.be = be1; s.p1.data = d1;
        s.mrdy = mrdy; s.mrsp = mrsp; s.mrdata = rd;
        return s;
    endfunction

    function automatic vec_t mkVec(stim_t in, logic mv, logic r0, logic r1, logic s0, logic s1,
                                   logic [31:0] addr, logic e);
        vec_t v;
        v.in = in; v.mv = mv; v.r0 = r0; v.r1 = r1; v.s0 = s0; v.s1 = s1;
        v.addr = addr; v.err = e;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveInputs(stim_t s);
        p0_req_valid = s.p0v; p0_req_be = s.p0.be; p0_req_addr = s.p0.addr; p0_req_data = s.p0.data;
        p1_req_valid = s.p1v; p1_req_be = s.p1.be; p1_req_addr = s.p1.addr; p1_req_data = s.p1.data;
        m_req_ready  = s.mrdy; m_rsp_valid = s.mrsp; m_rsp_data = s.mrdata;
    endtask

    task automatic modelReset();
        tag_q.delete();
        prefer_m = 0;
        err_m    = 1'b0;
    endtask

    // One clock of stimulus, checked against the queue model, then the model advances.
    task automatic applyStimulus(stim_t s);
        int   g;
        logic pop, room, mv, acc;
        mem_req_t want;
        @(posedge CLK);
        #1;
        driveInputs(s);
        #1;
        pop  = s.mrsp && (tag_q.size() > 0);
        room = (tag_q.size() < DEPTH) || pop;
`ifdef MEM_ARB_FIXED_PRIO_EN
        g = s.p1v ? 1 : 0;
`else
        g = (s.p0v && s.p1v) ? prefer_m : (s.p1v ? 1 : 0);
`endif
        mv  = room && (s.p0v || s.p1v);
        acc = mv && s.mrdy;
        checkOutput("m_req_valid", m_req_valid, mv);
        checkOutput("p0_req_ready", p0_req_ready, acc && (g == 0));
        checkOutput("p1_req_ready", p1_req_ready, acc && (g == 1));
        checkOutput("p0_rsp_valid", p0_rsp_valid, pop && (tag_q[0] == 0));
        checkOutput("p1_rsp_valid", p1_rsp_valid, pop && (tag_q[0] == 1));
        checkOutput("err", err, err_m);
        if (mv) begin
            want = (g == 1) ? s.p1 : s.p0;
            checkOutput("m_req_addr", m_req_addr, want.addr);
            checkOutput("m_req_be", m_req_be, want.be);
            checkOutput("m_req_data", m_req_data, want.data);
        end
        if (pop && tag_q[0] == 0) checkOutput("p0_rsp_data", p0_rsp_data, s.mrdata);
        if (pop && tag_q[0] == 1) checkOutput("p1_rsp_data", p1_rsp_data, s.mrdata);
        if (s.mrsp && tag_q.size() == 0) err_m = 1'b1;
        if (pop) void'(tag_q.pop_front());
        if (acc) begin
            tag_q.push_back(g);
            prefer_m = 1 - g;
        end
    endtask

    // Reset pulse deliberately placed off the clock edge; outputs must drop at once.
    task automatic doReset(string name);
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        checkOutput({name, "_m_req_valid"}, m_req_valid, 1'b0);
        checkOutput({name, "_p0_req_ready"}, p0_req_ready, 1'b0);
        checkOutput({name, "_p1_req_ready"}, p1_req_ready, 1'b0);
        checkOutput({name, "_p0_rsp_valid"}, p0_rsp_valid, 1'b0);
        checkOutput({name, "_p1_rsp_valid"}, p1_rsp_valid, 1'b0);
        checkOutput({name, "_err"}, err, 1'b0);
        driveInputs(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #10;
        RST_N = 1'b1;
        modelReset();
    endtask

    stim_t idle;
    stim_t both;
    stim_t s;
    vec_t  vecs[13];
    int    cnt0, cnt1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST_N = 1'b1;
        idle  = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        both  = mkStim(1, 32'h400, 4'h0, 32'h0, 1, 32'h500, 4'h3, 32'h5555, 1, 0, 0);
        driveInputs(idle);
        modelReset();

        vecs[0]  = mkVec(mkStim(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, 1, 0, 0, 0, 32'h100, 0);
        vecs[1]  = mkVec(mkStim(0, 0, 0, 0, 1, 32'h200, 4'hF, 32'hCAFEF00D, 1, 0, 0), 1, 0, 1, 0, 0, 32'h200, 0);
        vecs[2]  = mkVec(mkStim(1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, 1, 0, 0, 0, 32'h300, 0);
        vecs[3]  = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111), 0, 0, 0, 1, 0, 0, 0);
        vecs[4]  = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222), 0, 0, 0, 0, 1, 0, 0);
        vecs[5]  = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33333333), 0, 0, 0, 1, 0, 0, 0);
`ifdef MEM_ARB_FIXED_PRIO_EN
        vecs[6]  = mkVec(both, 1, 0, 1, 0, 0, 32'h500, 0);
        vecs[7]  = mkVec(both, 1, 0, 1, 0, 0, 32'h500, 0);
        vecs[8]  = mkVec(both, 1, 0, 1, 0, 0, 32'h500, 0);
        vecs[9]  = mkVec(both, 1, 0, 1, 0, 0, 32'h500, 0);
        vecs[12] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55555555), 0, 0, 0, 0, 1, 0, 0);
`else
        vecs[6]  = mkVec(both, 1, 0, 1, 0, 0, 32'h500, 0);
        vecs[7]  = mkVec(both, 1, 1, 0, 0, 0, 32'h400, 0);
        vecs[8]  = mkVec(both, 1, 0, 1, 0, 0, 32'h500, 0);
        vecs[9]  = mkVec(both, 1, 1, 0, 0, 0, 32'h400, 0);
        vecs[12] = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55555555), 0, 0, 0, 1, 0, 0, 0);
`endif
        vecs[10] = mkVec(both, 0, 0, 0, 0, 0, 0, 0);
        s = both; s.mrsp = 1'b1; s.mrdata = 32'h44444444;
        vecs[11] = mkVec(s, 1, 0, 1, 0, 1, 32'h500, 0);

        doReset("por");

        // Vector table: routing, contention, full-FIFO stall and pop+push at full.
        for (int i = 0; i < 13; i++) begin
            @(posedge CLK);
            #1;
            driveInputs(vecs[i].in);
            #1;
            checkOutput($sformatf("vec%0d_m_req_valid", i), m_req_valid, vecs[i].mv);
            checkOutput($sformatf("vec%0d_p0_req_ready", i), p0_req_ready, vecs[i].r0);
            checkOutput($sformatf("vec%0d_p1_req_ready", i), p1_req_ready, vecs[i].r1);
            checkOutput($sformatf("vec%0d_p0_rsp_valid", i), p0_rsp_valid, vecs[i].s0);
            checkOutput($sformatf("vec%0d_p1_rsp_valid", i), p1_rsp_valid, vecs[i].s1);
            checkOutput($sformatf("vec%0d_err", i), err, vecs[i].err);
            if (vecs[i].mv) checkOutput($sformatf("vec%0d_m_req_addr", i), m_req_addr, vecs[i].addr);
            if (vecs[i].s0) checkOutput($sformatf("vec%0d_p0_rsp_data", i), p0_rsp_data, vecs[i].in.mrdata);
            if (vecs[i].s1) checkOutput($sformatf("vec%0d_p1_rsp_data", i), p1_rsp_data, vecs[i].in.mrdata);
        end

        // Single port read with two cycles of memory latency.
        doReset("rst_single");
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      applyStimulus(mkStim(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0));
            else if (i == 2) applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF));
            else             applyStimulus(idle);
            if (p0_rsp_valid) begin
                cnt0++;
                checkOutput("single_rsp_data", p0_rsp_data, 32'hDEADBEEF);
            end
            if (p1_rsp_valid) cnt1++;
        end
        checkOutput("single_p0_rsp_count", cnt0, 1);
        checkOutput("single_p1_rsp_count", cnt1, 0);

        // Contention from reset, then fill to DEPTH and pop+push at full.
        doReset("rst_contend");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(both);
`ifdef MEM_ARB_FIXED_PRIO_EN
            checkOutput($sformatf("contend_p1_grant%0d", i), p1_req_ready, 1'b1);
            checkOutput($sformatf("contend_p0_grant%0d", i), p0_req_ready, 1'b0);
`else
            checkOutput($sformatf("contend_p1_grant%0d", i), p1_req_ready, (i % 2) == 1);
            checkOutput($sformatf("contend_p0_grant%0d", i), p0_req_ready, (i % 2) == 0);
`endif
        end
        applyStimulus(both);
        checkOutput("full_stall", m_req_valid, 1'b0);
        s = both; s.mrsp = 1'b1; s.mrdata = 32'h0BADF00D;
        applyStimulus(s);
        checkOutput("full_pop_push_valid", m_req_valid, 1'b1);
        checkOutput("full_pop_push_accept", p0_req_ready || p1_req_ready, 1'b1);
        applyStimulus(both);
        checkOutput("full_still_stalled", m_req_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA0000000 + i));
        end

        // Downstream backpressure holds p1's payload with no tag pushed.
        doReset("rst_bp");
        s = mkStim(0, 0, 0, 0, 1, 32'h700, 4'hF, 32'h12345678, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s);
            checkOutput($sformatf("bp_addr%0d", i), m_req_addr, 32'h700);
            checkOutput($sformatf("bp_ready%0d", i), p1_req_ready, 1'b0);
        end
        s.mrdy = 1'b1;
        applyStimulus(s);
        checkOutput("bp_accept", p1_req_ready, 1'b1);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h77777777));
        checkOutput("bp_rsp_p1", p1_rsp_valid, 1'b1);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h88888888));
        checkOutput("bp_extra_rsp_dropped", p0_rsp_valid || p1_rsp_valid, 1'b0);
        applyStimulus(idle);
        checkOutput("bp_err_sticky", err, 1'b1);

        // Asynchronous reset in the middle of a burst discards outstanding tags.
        doReset("rst_mid_pre");
        applyStimulus(both);
        applyStimulus(both);
        doReset("rst_mid");
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h99999999));
        checkOutput("mid_late_rsp_p0", p0_rsp_valid, 1'b0);
        checkOutput("mid_late_rsp_p1", p1_rsp_valid, 1'b0);
        applyStimulus(idle);
        checkOutput("mid_err_set", err, 1'b1);

        // Randomized traffic against the model; responses only when something is outstanding.
        doReset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            s = mkStim($urandom_range(0, 1), $urandom, 4'($urandom), $urandom,
                       $urandom_range(0, 1), $urandom, 4'($urandom), $urandom,
                       $urandom_range(0, 3) != 0,
                       (tag_q.size() > 0) && ($urandom_range(0, 2) != 0), $urandom);
            applyStimulus(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
